// File: rtl/lsu_sram_ctrl.sv
// LSU to 16-bit async SRAM bridge: each 32-bit word moves as two half-word
// accesses (low half, then high half), holding the pipeline until the ack.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_addr, i_wdata, i_bmask LSU byte address, store data, byte enables
//   i_wren, i_rden          level requests, held until o_ack
//   o_rdata, o_ack, o_stall load data, completion pulse, pipeline hold
//   o_sram_*, io_sram_dq    SRAM address, strobes (active low), data bus
module lsu_sram_ctrl #(
    parameter int PHASE_CYCLES = 2,
    parameter int ADDR_W       = 18
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_bmask,
    input  logic              i_wren,
    input  logic              i_rden,
    output logic [31:0]       o_rdata,
    output logic              o_ack,
    output logic              o_stall,
    output logic [17:0]       o_sram_addr,
    inout  wire  [15:0]       io_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    localparam int CW = $clog2(PHASE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        ACK
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [CW-1:0] cnt;
    logic [15:0] word_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic        wr_q;
    logic [15:0] rd_lo;
    logic [17:0] addr_hold;
    logic [17:0] addr_cur;

    logic req;
    logic last;
    logic active;
    logic hi;
    logic dq_en;
    logic [15:0] dq_out;
    logic addr_unused;

    assign addr_unused = ^i_addr[1:0];
    assign req  = i_wren | i_rden;
    assign last = (cnt == LAST);

    // Next state plus all strobes; strobes decode from the state register
    // so an async reset forces them inactive without waiting for a clock.
    always_comb begin
        state_nx    = state;
        active      = 1'b0;
        hi          = 1'b0;
        o_stall     = 1'b0;
        o_ack       = 1'b0;
        o_sram_ce_n = 1'b1;
        o_sram_oe_n = 1'b1;
        o_sram_we_n = 1'b1;
        o_sram_lb_n = 1'b1;
        o_sram_ub_n = 1'b1;
        dq_en       = 1'b0;
        unique case (state)
            IDLE: begin
                o_stall = req;
                if (req) state_nx = LO;
            end
            LO: begin
                active = 1'b1;
                if (last) state_nx = HI;
            end
            HI: begin
                active = 1'b1;
                hi     = 1'b1;
                if (last) state_nx = ACK;
            end
            ACK: begin
                o_ack    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (active) begin
            o_stall     = 1'b1;
            o_sram_ce_n = 1'b0;
            if (wr_q) begin
                dq_en = 1'b1;
                // we_n rises on the last phase cycle for data hold
                o_sram_we_n = last;
                o_sram_lb_n = hi ? ~bmask_q[2] : ~bmask_q[0];
                o_sram_ub_n = hi ? ~bmask_q[3] : ~bmask_q[1];
            end else begin
                o_sram_oe_n = 1'b0;
                o_sram_lb_n = 1'b0;
                o_sram_ub_n = 1'b0;
            end
        end
    end

    assign dq_out     = hi ? wdata_q[31:16] : wdata_q[15:0];
    assign io_sram_dq = dq_en ? dq_out : 16'hzzzz;

    assign addr_cur    = {1'b0, word_q, hi};
    assign o_sram_addr = active ? addr_cur : addr_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            bmask_q   <= '0;
            wr_q      <= 1'b0;
            rd_lo     <= '0;
            o_rdata   <= '0;
            addr_hold <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
            if (req) begin
                word_q  <= i_addr[17:2];
                wdata_q <= i_wdata;
                bmask_q <= i_bmask;
                wr_q    <= i_wren;
            end
        end else if (active) begin
            cnt       <= last ? '0 : cnt + 1'b1;
            addr_hold <= addr_cur;
            // low half is staged so o_rdata only changes on completion
            if (!wr_q && last) begin
                if (hi) o_rdata <= {io_sram_dq, rd_lo};
                else    rd_lo   <= io_sram_dq;
            end
        end
    end

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed bench for lsu_sram_ctrl with behavioural SRAM models,
// PHASE_CYCLES=2 (dut a) and PHASE_CYCLES=3 (dut b).
module tb_lsu_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  bmask = '0;
    logic        wren_a = 0, rden_a = 0, wren_b = 0, rden_b = 0;

    logic [31:0] rdata_a, rdata_b;
    logic        ack_a, ack_b, stall_a, stall_b;
    logic [17:0] sa_a, sa_b;
    wire  [15:0] dq_a, dq_b;
    logic ce_a, we_a, oe_a, lb_a, ub_a;
    logic ce_b, we_b, oe_b, lb_b, ub_b;

    logic [15:0] mem_a [0:1023];
    logic [15:0] mem_b [0:1023];

    int n_chk = 0;
    int n_err = 0;
    int viol = 0;

    logic [15:0] stall_tr, ack_tr, we_tr, lb_tr, ub_tr, oe_tr;
    logic [31:0] rd_tr [16];
    int lat;

    always #5 clk = ~clk;

    lsu_sram_ctrl #(.PHASE_CYCLES(2), .ADDR_W(18)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr),
        .i_wdata(wdata), .i_bmask(bmask),
        .i_wren(wren_a), .i_rden(rden_a),
        .o_rdata(rdata_a), .o_ack(ack_a), .o_stall(stall_a),
        .o_sram_addr(sa_a), .io_sram_dq(dq_a),
        .o_sram_ce_n(ce_a), .o_sram_we_n(we_a), .o_sram_oe_n(oe_a),
        .o_sram_lb_n(lb_a), .o_sram_ub_n(ub_a)
    );

    lsu_sram_ctrl #(.PHASE_CYCLES(3), .ADDR_W(18)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr),
        .i_wdata(wdata), .i_bmask(bmask),
        .i_wren(wren_b), .i_rden(rden_b),
        .o_rdata(rdata_b), .o_ack(ack_b), .o_stall(stall_b),
        .o_sram_addr(sa_b), .io_sram_dq(dq_b),
        .o_sram_ce_n(ce_b), .o_sram_we_n(we_b), .o_sram_oe_n(oe_b),
        .o_sram_lb_n(lb_b), .o_sram_ub_n(ub_b)
    );

    assign dq_a = (!ce_a && !oe_a) ? mem_a[sa_a[9:0]] : 16'hzzzz;
    assign dq_b = (!ce_b && !oe_b) ? mem_b[sa_b[9:0]] : 16'hzzzz;

    // SRAM write: sampled mid-cycle while we_n is low
    always @(negedge clk) begin
        if (!ce_a && !we_a) begin
            if (!lb_a) mem_a[sa_a[9:0]][7:0]  <= dq_a[7:0];
            if (!ub_a) mem_a[sa_a[9:0]][15:8] <= dq_a[15:8];
        end
        if (!ce_b && !we_b) begin
            if (!lb_b) mem_b[sa_b[9:0]][7:0]  <= dq_b[7:0];
            if (!ub_b) mem_b[sa_b[9:0]][15:8] <= dq_b[15:8];
        end
    end

    // bus sanity: no write strobe while reading, we_n implies ce_n
    always @(negedge clk) begin
        if (!we_a && ce_a) viol++;
        if (!we_b && ce_b) viol++;
        if (!oe_a && !we_a) viol++;
        if (!oe_b && !we_b) viol++;
        if (!oe_a && dq_a !== mem_a[sa_a[9:0]]) viol++;
        if (!oe_b && dq_b !== mem_b[sa_b[9:0]]) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit sel, input bit wr, input bit rd,
                        input logic [17:0] a, input logic [31:0] wd,
                        input logic [3:0] bm);
        stall_tr = '0; ack_tr = '0; we_tr = '0;
        lb_tr = '0; ub_tr = '0; oe_tr = '0;
        @(posedge clk);
        #1;
        addr = a; wdata = wd; bmask = bm;
        if (sel) begin
            wren_b = wr; rden_b = rd;
        end else begin
            wren_a = wr; rden_a = rd;
        end
        lat = -1;
        for (int c = 0; c < 16 && lat < 0; c++) begin
            @(negedge clk);
            stall_tr[c] = sel ? stall_b : stall_a;
            ack_tr[c]   = sel ? ack_b : ack_a;
            we_tr[c]    = sel ? we_b : we_a;
            lb_tr[c]    = sel ? lb_b : lb_a;
            ub_tr[c]    = sel ? ub_b : ub_a;
            oe_tr[c]    = sel ? oe_b : oe_a;
            rd_tr[c]    = sel ? rdata_b : rdata_a;
            if (ack_tr[c]) lat = c;
        end
        wren_a = 0; rden_a = 0; wren_b = 0; rden_b = 0;
        if (lat < 0) lat = 15;
    endtask

    int acks;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        @(negedge clk);
        chk("rst_stall", {31'b0, stall_a}, 32'd0);
        chk("rst_ack", {31'b0, ack_a}, 32'd0);
        chk("rst_rdata", rdata_a, 32'd0);
        chk("rst_addr", {14'b0, sa_a}, 32'd0);
        chk("rst_strobes", {27'b0, ce_a, we_a, oe_a, lb_a, ub_a}, 32'h1f);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // word store
        xfer(0, 1, 0, 18'h00100, 32'hDEADBEEF, 4'b1111);
        chk("st_lat", lat, 32'd5);
        chk("st_stall", {26'b0, stall_tr[5:0]}, 32'h1f);
        chk("st_ack", {26'b0, ack_tr[5:0]}, 32'h20);
        chk("st_lo", {16'b0, mem_a[10'h080]}, 32'hBEEF);
        chk("st_hi", {16'b0, mem_a[10'h081]}, 32'hDEAD);
        chk("st_rdata_kept", rd_tr[5], 32'd0);

        // word load
        xfer(0, 0, 1, 18'h00100, 32'h0, 4'b0000);
        chk("ld_lat", lat, 32'd5);
        chk("ld_data", rd_tr[lat], 32'hDEADBEEF);

        // byte store to byte 1
        xfer(0, 1, 0, 18'h00100, 32'h0000AA00, 4'b0010);
        chk("bs_ub", {28'b0, ub_tr[4:1]}, 32'hc);
        chk("bs_lb", {28'b0, lb_tr[4:1]}, 32'hf);
        chk("bs_we", {28'b0, we_tr[4:1]}, 32'ha);
        xfer(0, 0, 1, 18'h00100, 32'h0, 4'b0000);
        chk("bs_read", rd_tr[lat], 32'hDEADAAEF);

        // write wins when both requests are high
        xfer(0, 1, 1, 18'h00200, 32'h12345678, 4'b1111);
        chk("both_oe", {26'b0, oe_tr[5:0]}, 32'h3f);
        chk("both_we", {28'b0, we_tr[4:1]}, 32'ha);
        chk("both_rdata", rd_tr[lat], 32'hDEADAAEF);
        xfer(0, 0, 1, 18'h00200, 32'h0, 4'b0000);
        chk("both_hold", rd_tr[4], 32'hDEADAAEF);
        chk("both_read", rd_tr[lat], 32'h12345678);

        // reset in the middle of a store
        @(posedge clk);
        #1;
        addr = 18'h00300; wdata = 32'hCAFEF00D; bmask = 4'b1111;
        wren_a = 1;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        wren_a = 0;
        #1;
        chk("mr_strobes", {27'b0, ce_a, we_a, oe_a, lb_a, ub_a}, 32'h1f);
        chk("mr_stall", {31'b0, stall_a}, 32'd0);
        chk("mr_addr", {14'b0, sa_a}, 32'd0);
        acks = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        chk("mr_noack", acks, 32'd0);
        chk("mr_idle", {31'b0, stall_a}, 32'd0);
        chk("mr_lo", {16'b0, mem_a[10'h180]}, 32'hF00D);
        chk("mr_hi", {16'b0, mem_a[10'h181]}, 32'h0000);

        // three-cycle phases
        xfer(1, 1, 0, 18'h00100, 32'h0BADF00D, 4'b1111);
        chk("p3_lat", lat, 32'd7);
        chk("p3_we", {26'b0, we_tr[6:1]}, 32'h24);
        chk("p3_stall", {24'b0, stall_tr[7:0]}, 32'h7f);
        xfer(1, 0, 1, 18'h00100, 32'h0, 4'b0000);
        chk("p3_rlat", lat, 32'd7);
        chk("p3_read", rd_tr[lat], 32'h0BADF00D);

        @(negedge clk);
        chk("bus_viol", viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
